trng_word_collector: RTL and testbench



---
 rtl/trng_word_collector.sv | 208 ++++++++++++++++++++
 tb/tb_trng_word_collector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_word_collector.sv
// Purpose: drives the ring-oscillator run control, samples random_in every SAMPLE_DIV clocks, optionally von Neumann debiases (TRNG_VN_DEBIAS_EN) and packs WIDTH-bit words; a repetition-count test latches health_fail.
// Latency: WARMUP_CYCLES after enable, then one raw sample per SAMPLE_DIV cycles; word_valid rises the cycle after the last accepted bit.
// Backpressure: a full word is held in FULL with sampling paused until word_valid & word_ready; enable falling never drops word_valid.
module trng_word_collector #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_DIV    = 4,
    parameter int WARMUP_CYCLES = 16,
    parameter int RCT_LIMIT     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             random_in,
    output logic             osc_en,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             health_fail,
    input  logic             health_clr
);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RCT_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [RW-1:0] RCT_MAX   = RW'(RCT_LIMIT);

    typedef enum logic [2:0] {IDLE, WARMUP, COLLECT, FULL, FAULT} state_t;

    state_t           state, state_d;
    logic [WW-1:0]    warm_cnt, warm_cnt_d;
    logic [DW-1:0]    div_cnt, div_cnt_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic [RW-1:0]    run_cnt, run_cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             prev_vld, prev_vld_d;
    logic             prev_bit, prev_bit_d;
    logic             fail, fail_d;
`ifdef TRNG_VN_DEBIAS_EN
    logic             pair_vld, pair_vld_d;
    logic             pair_bit, pair_bit_d;
`endif

    logic [RW-1:0]    run_next;
    logic             trip;
    logic             emit;
    logic             emit_bit;

    // Repetition count on the raw bit; the first sample after warmup has no predecessor.
    always_comb begin
        run_next = RW'(1);
        if (prev_vld && (random_in == prev_bit)) begin
            run_next = (run_cnt == RCT_MAX) ? run_cnt : run_cnt + 1'b1;
        end
        trip = (run_next == RCT_MAX);
    end

`ifdef TRNG_VN_DEBIAS_EN
    // Second sample of a pair: 01 emits 0, 10 emits 1, i.e. the first bit when they differ.
    always_comb begin
        emit     = pair_vld && (pair_bit != random_in);
        emit_bit = pair_bit;
    end
`else
    always_comb begin
        emit     = 1'b1;
        emit_bit = random_in;
    end
`endif

    always_comb begin
        state_d    = state;
        warm_cnt_d = warm_cnt;
        div_cnt_d  = div_cnt;
        bit_cnt_d  = bit_cnt;
        run_cnt_d  = run_cnt;
        shreg_d    = shreg;
        prev_vld_d = prev_vld;
        prev_bit_d = prev_bit;
        fail_d     = fail;
`ifdef TRNG_VN_DEBIAS_EN
        pair_vld_d = pair_vld;
        pair_bit_d = pair_bit;
`endif
        case (state)
            IDLE: begin
                warm_cnt_d = '0;
                div_cnt_d  = '0;
                bit_cnt_d  = '0;
                run_cnt_d  = '0;
                shreg_d    = '0;
                prev_vld_d = 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
                pair_vld_d = 1'b0;
`endif
                if (enable) state_d = WARMUP;
            end
            WARMUP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (warm_cnt == WARM_LAST) begin
                    state_d    = COLLECT;
                    warm_cnt_d = '0;
                    div_cnt_d  = '0;
                end else begin
                    warm_cnt_d = warm_cnt + 1'b1;
                end
            end
            COLLECT: begin
                if (!enable) begin
                    state_d   = IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
`ifdef TRNG_VN_DEBIAS_EN
                    pair_vld_d = 1'b0;
`endif
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt_d  = '0;
                    prev_vld_d = 1'b1;
                    prev_bit_d = random_in;
                    run_cnt_d  = run_next;
`ifdef TRNG_VN_DEBIAS_EN
                    pair_vld_d = !pair_vld;
                    pair_bit_d = random_in;
`endif
                    // A trip wins over a word completing on the same sample.
                    if (trip) begin
                        state_d   = FAULT;
                        fail_d    = 1'b1;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
`ifdef TRNG_VN_DEBIAS_EN
                        pair_vld_d = 1'b0;
`endif
                    end else if (emit) begin
                        shreg_d = {shreg[WIDTH-2:0], emit_bit};
                        if (bit_cnt == BIT_LAST) begin
                            state_d   = FULL;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            FULL: begin
                if (word_ready) begin
                    state_d   = enable ? COLLECT : IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            FAULT: begin
                if (health_clr) begin
                    state_d    = IDLE;
                    fail_d     = 1'b0;
                    run_cnt_d  = '0;
                    prev_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            warm_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            shreg    <= '0;
            prev_vld <= 1'b0;
            prev_bit <= 1'b0;
            fail     <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            pair_vld <= 1'b0;
            pair_bit <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            warm_cnt <= warm_cnt_d;
            div_cnt  <= div_cnt_d;
            bit_cnt  <= bit_cnt_d;
            run_cnt  <= run_cnt_d;
            shreg    <= shreg_d;
            prev_vld <= prev_vld_d;
            prev_bit <= prev_bit_d;
            fail     <= fail_d;
`ifdef TRNG_VN_DEBIAS_EN
            pair_vld <= pair_vld_d;
            pair_bit <= pair_bit_d;
`endif
        end
    end

    assign osc_en      = (state == WARMUP) || (state == COLLECT) || (state == FULL);
    assign word_valid  = (state == FULL);
    assign word_data   = shreg;
    assign health_fail = fail;

endmodule

// File: tb/tb_trng_word_collector.sv
// Randomized bench for trng_word_collector: raw samples land on predicted sample ticks, other cycles carry random noise.
// Reference: queues of raw samples, pending pair and emitted bits; words and health trips derived from those lists.
module tb_trng_word_collector;
    localparam int WIDTH         = 8;
    localparam int SAMPLE_DIV    = 4;
    localparam int WARMUP_CYCLES = 16;
    localparam int RCT_LIMIT     = 32;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             random_in;
    logic             osc_en;
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             health_fail;
    logic             health_clr;

    trng_word_collector #(
        .WIDTH(WIDTH), .SAMPLE_DIV(SAMPLE_DIV),
        .WARMUP_CYCLES(WARMUP_CYCLES), .RCT_LIMIT(RCT_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .random_in(random_in),
        .osc_en(osc_en), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .health_fail(health_fail), .health_clr(health_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state
    bit          raw_hist[$];
    bit          pend[$];
    bit          wbits[$];
    logic [31:0] m_word;
    bit          m_trip;
    bit          m_full;
    bit          tripped;
    int          hold_cycles;
    bit          drop_en_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        raw_hist.delete();
        pend.delete();
        wbits.delete();
    endtask

    task automatic model_sample(input bit b);
        int run;
        raw_hist.push_back(b);
        run = 0;
        for (int i = raw_hist.size() - 1; i >= 0 && raw_hist[i] == b; i--) run++;
        m_trip = (run >= RCT_LIMIT);
        m_full = 1'b0;
        if (m_trip) begin
            pend.delete();
            wbits.delete();
            return;
        end
`ifdef TRNG_VN_DEBIAS_EN
        if (pend.size() == 0) begin
            pend.push_back(b);
        end else begin
            if (pend[0] != b) wbits.push_back(pend[0]);
            pend.delete();
        end
`else
        wbits.push_back(b);
`endif
        if (wbits.size() == WIDTH) begin
            m_word = '0;
            foreach (wbits[i]) m_word = (m_word << 1) | 32'(wbits[i]);
            m_full = 1'b1;
            wbits.delete();
        end
    endtask

    // IDLE -> WARMUP on the first edge, then WARMUP_CYCLES cycles with no sampling.
    task automatic start_warmup();
        enable = 1'b1;
        random_in = 1'($urandom_range(0, 1));
        step();
        chk("start_osc", osc_en, 1);
        for (int i = 0; i < WARMUP_CYCLES; i++) begin
            random_in = 1'($urandom_range(0, 1));
            step();
            chk("warm_osc", osc_en, 1);
            chk("warm_vld", word_valid, 0);
        end
        model_clear();
    endtask

    // Noise on off-tick cycles, then the raw bit on the sample tick.
    task automatic feed_raw(input bit b);
        for (int i = 0; i < SAMPLE_DIV - 1; i++) begin
            random_in = 1'($urandom_range(0, 1));
            step();
        end
        random_in = b;
        step();
        model_sample(b);
        if (m_trip) begin
            chk("trip_hf", health_fail, 1);
            chk("trip_osc", osc_en, 0);
            chk("trip_vld", word_valid, 0);
            tripped = 1'b1;
        end else if (m_full) begin
            chk("full_vld", word_valid, 1);
            chk("full_dat", 32'(word_data), m_word);
            for (int i = 0; i < hold_cycles; i++) begin
                if (i == 0 && drop_en_full) enable = 1'b0;
                random_in = 1'($urandom_range(0, 1));
                step();
                chk("hold_vld", word_valid, 1);
                chk("hold_dat", 32'(word_data), m_word);
            end
            word_ready = 1'b1;
            random_in = 1'($urandom_range(0, 1));
            step();
            word_ready = 1'b0;
            chk("xfer_vld", word_valid, 0);
            chk("xfer_osc", osc_en, 32'(enable));
        end else begin
            chk("busy_vld", word_valid, 0);
            chk("busy_hf", health_fail, 0);
        end
    endtask

    task automatic feed_until_word();
        int n;
        n = 0;
        m_full = 1'b0;
        while (!m_full && !tripped && n < 200) begin
            feed_raw(1'($urandom_range(0, 1)));
            n++;
        end
        if (!m_full && !tripped) chk("word_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat_word[8];
        bit pat_vn[10];
        int guard;
        pat_word = '{1, 0, 1, 1, 0, 0, 1, 0};
        pat_vn   = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 0};
        tripped = 1'b0;
        drop_en_full = 1'b0;
        hold_cycles = 0;
        m_word = '0;

        // Reset dominates enable, ready and clear.
        rst_n = 1'b0; enable = 1'b1; word_ready = 1'b1; health_clr = 1'b1; random_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_osc", osc_en, 0);
        chk("rst_vld", word_valid, 0);
        chk("rst_hf", health_fail, 0);
        chk("rst_dat", 32'(word_data), 0);
        rst_n = 1'b1; enable = 1'b0; word_ready = 1'b0; health_clr = 1'b0;
        step();
        chk("idle_osc", osc_en, 0);

        // Enable dropped during warmup returns to IDLE.
        enable = 1'b1;
        step();
        chk("wa_osc1", osc_en, 1);
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        step();
        chk("wa_osc0", osc_en, 0);

        // Fixed pattern, then backpressure for 50 cycles.
        start_warmup();
        hold_cycles = 50;
        m_full = 1'b0;
        foreach (pat_word[i]) feed_raw(pat_word[i]);
        if (!m_full) feed_until_word();
        hold_cycles = 0;

        // Von Neumann pattern; then finish the word with random raw bits.
        foreach (pat_vn[i]) begin
            hold_cycles = $urandom_range(0, 3);
            feed_raw(pat_vn[i]);
        end
        for (int w = 0; w < 3; w++) begin
            hold_cycles = $urandom_range(0, 4);
            feed_until_word();
        end

        // Abort after 5 accepted bits; next word must hold only new bits.
        guard = 0;
        while (wbits.size() != 5 && guard < 200) begin
            feed_raw(1'($urandom_range(0, 1)));
            guard++;
        end
        chk("abort_reach", 32'(wbits.size()), 5);
        enable = 1'b0;
        step();
        chk("abort_osc", osc_en, 0);
        chk("abort_vld", word_valid, 0);
        model_clear();
        start_warmup();
        hold_cycles = 2;
        feed_until_word();

        // Fresh warmup, then a constant-1 raw stream trips the repetition test.
        enable = 1'b0;
        step();
        chk("pre_trip_osc", osc_en, 0);
        start_warmup();
        hold_cycles = 0;
        guard = 0;
        while (!tripped && guard < RCT_LIMIT + 8) begin
            feed_raw(1'b1);
            guard++;
        end
        chk("trip_count", guard, RCT_LIMIT);
        for (int i = 0; i < 5; i++) begin
            random_in = 1'($urandom_range(0, 1));
            step();
            chk("fault_hf", health_fail, 1);
            chk("fault_osc", osc_en, 0);
            chk("fault_vld", word_valid, 0);
        end

        // Clear with enable high: IDLE first, WARMUP one cycle later.
        health_clr = 1'b1;
        step();
        health_clr = 1'b0;
        chk("clr_hf", health_fail, 0);
        chk("clr_osc", osc_en, 0);
        tripped = 1'b0;
        start_warmup();

        // Enable falls while a word is waiting: the word stays valid until taken.
        drop_en_full = 1'b1;
        hold_cycles = 3;
        feed_until_word();
        chk("end_osc", osc_en, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
